// File: rtl/axilite_csr_pkg.sv
// axilite_csr_pkg: op, response and state encodings shared by the AXI-Lite CSR master
package axilite_csr_pkg;
  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;
  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_A,
    RD_R,
    POLL_WAIT,
    RSP
  } state_e;
  function automatic op_e norm_op(input logic [1:0] op);
    return op == OP_WRITE ? OP_WRITE : op == OP_POLL ? OP_POLL : OP_READ;
  endfunction
endpackage

// File: rtl/axilite_csr_master.sv
// axilite_csr_master: single-outstanding AXI-Lite master running WRITE, READ and POLL commands
module axilite_csr_master
  import axilite_csr_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int POLL_INTERVAL = 20,
  parameter int POLL_MAX      = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH-1:0]   cmd_mask,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    m_axilite_awvalid,
  input  logic                    m_axilite_awready,
  output logic [ADDR_WIDTH-1:0]   m_axilite_awaddr,
  output logic [2:0]              m_axilite_awprot,
  output logic                    m_axilite_wvalid,
  input  logic                    m_axilite_wready,
  output logic [DATA_WIDTH-1:0]   m_axilite_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axilite_wstrb,
  input  logic                    m_axilite_bvalid,
  output logic                    m_axilite_bready,
  input  logic [1:0]              m_axilite_bresp,
  output logic                    m_axilite_arvalid,
  input  logic                    m_axilite_arready,
  output logic [ADDR_WIDTH-1:0]   m_axilite_araddr,
  output logic [2:0]              m_axilite_arprot,
  input  logic                    m_axilite_rvalid,
  output logic                    m_axilite_rready,
  input  logic [DATA_WIDTH-1:0]   m_axilite_rdata,
  input  logic [1:0]              m_axilite_rresp
);
  localparam int CW = POLL_MAX > 0 ? $clog2(POLL_MAX + 1) : 1;
  localparam int IW = POLL_INTERVAL > 1 ? $clog2(POLL_INTERVAL) : 1;
  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [IW-1:0]         ivl_q, ivl_d;
  logic [CW-1:0]         att_q, att_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  tmo_q, tmo_d;
  logic                  cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, hit;
  assign cmd_ready         = resetn && state_q == IDLE;
  assign m_axilite_awvalid = state_q == WR && !aw_done_q;
  assign m_axilite_wvalid  = state_q == WR && !w_done_q;
  assign m_axilite_bready  = state_q == WR_B;
  assign m_axilite_arvalid = state_q == RD_A;
  assign m_axilite_rready  = state_q == RD_R;
  assign rsp_valid         = state_q == RSP;
  assign m_axilite_awaddr  = addr_q;
  assign m_axilite_araddr  = addr_q;
  assign m_axilite_wdata   = wdata_q;
  assign m_axilite_awprot  = '0;
  assign m_axilite_arprot  = '0;
  assign m_axilite_wstrb   = '1;
  assign rsp_rdata         = rdata_q;
  assign rsp_resp          = resp_q;
  assign rsp_timeout       = tmo_q;
  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = m_axilite_awvalid && m_axilite_awready;
  assign w_fire   = m_axilite_wvalid && m_axilite_wready;
  assign b_fire   = m_axilite_bvalid && m_axilite_bready;
  assign ar_fire  = m_axilite_arvalid && m_axilite_arready;
  assign r_fire   = m_axilite_rvalid && m_axilite_rready;
  assign hit      = ((m_axilite_rdata ^ wdata_q) & mask_q) == '0;
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ivl_d     = ivl_q;
    att_d     = att_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      IDLE: if (cmd_fire) begin
        op_d      = norm_op(cmd_op);
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        mask_d    = cmd_mask;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        att_d     = '0;
        rdata_d   = '0;
        resp_d    = RESP_OKAY;
        tmo_d     = 1'b0;
        state_d   = norm_op(cmd_op) == OP_WRITE ? WR : RD_A;
      end
      WR: begin
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        state_d   = aw_done_d && w_done_d ? WR_B : WR;
      end
      WR_B: if (b_fire) begin
        resp_d  = m_axilite_bresp;
        rdata_d = '0;
        state_d = RSP;
      end
      RD_A: if (ar_fire) begin
        // saturate so an unlimited poll never wraps the attempt count
        att_d   = &att_q ? att_q : att_q + CW'(1);
        state_d = RD_R;
      end
      RD_R: if (r_fire) begin
        rdata_d = m_axilite_rdata;
        resp_d  = m_axilite_rresp;
        ivl_d   = '0;
        if (op_q != OP_POLL || hit || m_axilite_rresp != RESP_OKAY) state_d = RSP;
        else if (POLL_MAX != 0 && att_q == CW'(POLL_MAX)) begin
          tmo_d   = 1'b1;
          state_d = RSP;
        end else state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        ivl_d   = ivl_q + IW'(1);
        state_d = ivl_q == IW'(POLL_INTERVAL - 1) ? RD_A : POLL_WAIT;
      end
      RSP: state_d = rsp_ready ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      op_q      <= OP_WRITE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ivl_q     <= '0;
      att_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ivl_q     <= ivl_d;
      att_q     <= att_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      tmo_q     <= tmo_d;
    end
  end
endmodule

// File: tb/tb_axilite_csr_master.sv
// tb_axilite_csr_master: directed bench with a reactive AXI-Lite slave and handshake monitors
module tb_axilite_csr_master;
  import axilite_csr_pkg::*;
  localparam int PI = 3;
  localparam int PM = 4;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0, cmd_mask = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  int checks = 0, errors = 0, cyc = 0;
  int aw_dly = 0, r_dly = 0, ar_base = 0;
  logic [1:0]  bresp_cfg = 2'd0, rresp_cfg = 2'd0;
  logic [31:0] rd_tab [8];
  int aw_wait = 0, r_wait = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, bvio = 0, ovl = 0;
  int ar_cyc [16];
  logic        aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0;
  logic [31:0] rd_cur = '0, w_seen = '0;
  logic [11:0] aw_seen = '0;
  always #5 clk = ~clk;
  axilite_csr_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .POLL_INTERVAL(PI), .POLL_MAX(PM)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_axilite_awvalid(awvalid), .m_axilite_awready(awready), .m_axilite_awaddr(awaddr),
    .m_axilite_awprot(awprot),
    .m_axilite_wvalid(wvalid), .m_axilite_wready(wready), .m_axilite_wdata(wdata),
    .m_axilite_wstrb(wstrb),
    .m_axilite_bvalid(bvalid), .m_axilite_bready(bready), .m_axilite_bresp(bresp),
    .m_axilite_arvalid(arvalid), .m_axilite_arready(arready), .m_axilite_araddr(araddr),
    .m_axilite_arprot(arprot),
    .m_axilite_rvalid(rvalid), .m_axilite_rready(rready), .m_axilite_rdata(rdata),
    .m_axilite_rresp(rresp)
  );
  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = 1'b1;
  assign bvalid  = aw_got && w_got;
  assign bresp   = bresp_cfg;
  assign arready = 1'b1;
  assign rvalid  = r_pend && (r_wait >= r_dly);
  assign rdata   = rd_cur;
  assign rresp   = rresp_cfg;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      aw_wait <= 0;
      r_wait  <= 0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      if (awvalid && awready) begin
        aw_hs   <= aw_hs + 1;
        aw_got  <= 1'b1;
        aw_wait <= 0;
        aw_seen <= awaddr;
      end
      if (wvalid && wready) begin
        w_hs   <= w_hs + 1;
        w_got  <= 1'b1;
        w_seen <= wdata;
      end
      if (bvalid && bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bready && !(aw_got && w_got)) bvio <= bvio + 1;
      if (arvalid && (awvalid || wvalid)) ovl <= ovl + 1;
      if (r_pend && !(rvalid && rready)) r_wait <= r_wait + 1;
      if (arvalid && arready) begin
        ar_cyc[ar_hs % 16] <= cyc;
        ar_hs  <= ar_hs + 1;
        r_pend <= 1'b1;
        r_wait <= 0;
        rd_cur <= (ar_hs - ar_base < 8) ? rd_tab[(ar_hs - ar_base) % 8] : '0;
      end
      if (rvalid && rready) r_pend <= 1'b0;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_cmd(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] mk, input int hold, output int lat,
                        output logic [31:0] rd, output logic [1:0] rs, output logic to);
    int n;
    int acc;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_mask  = mk;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrives", rsp_valid, 1);
    lat = cyc - acc;
    rd  = rsp_rdata;
    rs  = rsp_resp;
    to  = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_resp", rsp_resp, rs);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, n, a0, w0, r0;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;
    for (int i = 0; i < 8; i++) rd_tab[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_handshakes", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
    resetn = 1'b1;
    #1;
    chk("ready_after_reset", cmd_ready, 1);
    chk("wstrb_ones", wstrb, 4'hf);
    chk("prot_zero", {awprot, arprot}, 0);
    // write with AW stalled three cycles, W immediate
    aw_dly = 3;
    a0 = aw_hs;
    w0 = w_hs;
    do_cmd(OP_WRITE, 12'h008, 32'h3, 32'h0, 0, lat, rd, rs, to);
    chk("wr_aw_count", aw_hs - a0, 1);
    chk("wr_w_count", w_hs - w0, 1);
    chk("wr_bready_order", bvio, 0);
    chk("wr_awaddr", aw_seen, 12'h008);
    chk("wr_wdata", w_seen, 32'h3);
    chk("wr_resp", rs, 0);
    chk("wr_rdata", rd, 0);
    chk("wr_timeout", to, 0);
    aw_dly = 0;
    do_cmd(OP_WRITE, 12'h00c, 32'h5a5a_0001, 32'h0, 0, lat, rd, rs, to);
    chk("wr_latency", lat, 3);
    // zero-wait read
    ar_base = ar_hs;
    rd_tab[0] = 32'h1;
    do_cmd(OP_READ, 12'h000, 32'h0, 32'h0, 0, lat, rd, rs, to);
    chk("rd_latency", lat, 3);
    chk("rd_rdata", rd, 32'h1);
    chk("rd_resp", rs, 0);
    chk("rd_timeout", to, 0);
    // reserved op behaves as read
    ar_base = ar_hs;
    a0 = aw_hs;
    r0 = ar_hs;
    rd_tab[0] = 32'hdead_beef;
    do_cmd(OP_RSVD, 12'h044, 32'h0, 32'h0, 0, lat, rd, rs, to);
    chk("op3_ar_count", ar_hs - r0, 1);
    chk("op3_aw_count", aw_hs - a0, 0);
    chk("op3_rdata", rd, 32'hdead_beef);
    chk("op3_latency", lat, 3);
    // poll: 0, 0, then 1 matches
    ar_base = ar_hs;
    r0 = ar_hs;
    rd_tab[0] = 32'h0;
    rd_tab[1] = 32'h0;
    rd_tab[2] = 32'h1;
    do_cmd(OP_POLL, 12'h000, 32'h1, 32'h1, 0, lat, rd, rs, to);
    chk("poll_ar_count", ar_hs - r0, 3);
    chk("poll_gap1", (ar_cyc[(r0 + 1) % 16] - ar_cyc[r0 % 16]) >= PI + 2, 1);
    chk("poll_gap2", (ar_cyc[(r0 + 2) % 16] - ar_cyc[(r0 + 1) % 16]) >= PI + 2, 1);
    chk("poll_rdata", rd, 32'h1);
    chk("poll_timeout", to, 0);
    chk("poll_resp", rs, 0);
    // poll that never matches times out after PM attempts
    ar_base = ar_hs;
    r0 = ar_hs;
    for (int i = 0; i < 8; i++) rd_tab[i] = 32'hffff_fff0;
    do_cmd(OP_POLL, 12'h020, 32'h1, 32'h1, 0, lat, rd, rs, to);
    chk("pto_ar_count", ar_hs - r0, PM);
    chk("pto_timeout", to, 1);
    chk("pto_rdata", rd & 32'h1, 0);
    // poll aborted by an error response
    ar_base = ar_hs;
    r0 = ar_hs;
    rresp_cfg = RESP_SLVERR;
    do_cmd(OP_POLL, 12'h024, 32'h1, 32'h1, 0, lat, rd, rs, to);
    chk("perr_ar_count", ar_hs - r0, 1);
    chk("perr_resp", rs, 2);
    chk("perr_timeout", to, 0);
    rresp_cfg = RESP_OKAY;
    // write with SLVERR and a stalled response consumer
    bresp_cfg = RESP_SLVERR;
    do_cmd(OP_WRITE, 12'h010, 32'h77, 32'h0, 5, lat, rd, rs, to);
    chk("slverr_resp", rs, 2);
    chk("slverr_timeout", to, 0);
    bresp_cfg = RESP_OKAY;
    @(negedge clk);
    chk("ready_after_rsp", cmd_ready, 1);
    // reset while waiting for R
    r_dly = 1000;
    cmd_valid = 1'b1;
    cmd_op    = OP_READ;
    cmd_addr  = 12'h030;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_in_rd_r", rready, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    resetn = 1'b1;
    #1;
    chk("mid_ready_release", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", {rsp_valid, arvalid, rready}, 0);
    end
    r_dly = 0;
    ar_base = ar_hs;
    rd_tab[0] = 32'h0bad_f00d;
    do_cmd(OP_READ, 12'h030, 32'h0, 32'h0, 0, lat, rd, rs, to);
    chk("mid_next_rdata", rd, 32'h0bad_f00d);
    chk("mid_next_latency", lat, 3);
    chk("no_ar_aw_overlap", ovl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
